mux_arb_stage: RTL and testbench

- Parametrised successor to the float adder's registered 2:1 operand mux.
- Selects one of NCH WIDTH-bit input channels and stores it in a single output pipeline register.
- Uses a valid/ready handshake on every channel and on the output.
- Two modes: fixed select (software/FSM-driven `sel`) and round-robin arbitration across requesting channels. Sits between operand sources and the adder's alignment stage.

---
 rtl/mux_arb_stage_pkg.sv | 13 +
 rtl/mux_arb_stage_rr_arbiter.sv | 36 +++
 rtl/mux_arb_stage.sv | 77 +++++++
 tb/tb_mux_arb_stage.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_stage_pkg.sv
// Shared definitions for the operand select/arbitration stage feeding the
// float adder's alignment stage.
package mux_arb_stage_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Channel-id width; a single channel would otherwise collapse to zero bits.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mux_arb_stage_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins,
// searching upward modulo NCH.
module rr_arbiter
    import mux_arb_stage_pkg::*;
#(
    parameter  int NCH  = 4,
    localparam int SELW = sel_width(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic [NCH-1:0]  grant,
    output logic [SELW-1:0] grant_idx
);

    int   c;
    logic found;

    // NOTE: every combinational output gets a default before the loop so no
    // path leaves a variable unassigned, which would infer a latch.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        c         = 0;
        for (int k = 0; k < NCH; k++) begin
            c = int'(ptr) + k;
            if (c >= NCH) c = c - NCH;
            if (!found && req[c]) begin
                grant[c]  = 1'b1;
                grant_idx = SELW'(c);
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_arb_stage.sv
// Registered NCH:1 operand select with valid/ready on every channel; fixed
// select or round-robin arbitration, one word per cycle at full throughput.
module mux_arb_stage
    import mux_arb_stage_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int NCH   = 4,
    localparam int SELW  = sel_width(NCH)
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_ch,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic [SELW-1:0]  rr_ptr;
    logic [NCH-1:0]   rr_grant;
    logic [SELW-1:0]  rr_idx;
    logic [NCH-1:0]   fixed_grant;
    logic [NCH-1:0]   grant;
    logic [SELW-1:0]  grant_idx;
    logic [SELW-1:0]  next_ptr;
    logic [WIDTH-1:0] grant_data;
    logic             space;
    logic             xfer;

    rr_arbiter #(.NCH(NCH)) u_arb (
        .req       (in_valid),
        .ptr       (rr_ptr),
        .grant     (rr_grant),
        .grant_idx (rr_idx)
    );

    assign space = !out_valid || out_ready;

    always_comb begin
        fixed_grant = '0;
        grant_data  = '0;
        // An out-of-range sel matches no channel and so grants nothing.
        for (int i = 0; i < NCH; i++)
            fixed_grant[i] = (int'(sel) == i);
        grant     = (mode == MODE_RR) ? rr_grant : fixed_grant;
        grant_idx = (mode == MODE_RR) ? rr_idx : sel;
        in_ready  = (space && !res) ? grant : '0;
        for (int i = 0; i < NCH; i++)
            if (grant[i]) grant_data = in_data[i*WIDTH +: WIDTH];
    end

    assign xfer     = |(in_valid & in_ready);
    assign next_ptr = (int'(grant_idx) == NCH - 1) ? '0 : grant_idx + SELW'(1);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (res) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            rr_ptr    <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= grant_data;
            out_ch    <= grant_idx;
            if (mode == MODE_RR) rr_ptr <= next_ptr;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_arb_stage.sv
// Self-checking bench for mux_arb_stage: vector table, directed corner
// sequences, randomized traffic against a reference model, and an NCH=3 build.
module tb_mux_arb_stage;

    localparam int W = 32;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           res, mode, out_ready, out_valid;
    logic [1:0]     sel, out_ch;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid, in_ready;
    logic [W-1:0]   out_data;

    logic       res3, mode3, ordy3, ov3;
    logic [1:0] sel3, och3;
    logic [23:0] in_data3;
    logic [2:0] iv3, ir3;
    logic [7:0] od3;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic        m_valid;
    logic [W-1:0] m_data;
    int          m_ch;
    int          m_ptr;

    always #5 clk = ~clk;

    mux_arb_stage #(.WIDTH(W), .NCH(N)) dut (
        .clk(clk), .res(res), .mode(mode), .sel(sel), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
    );

    mux_arb_stage #(.WIDTH(8), .NCH(3)) dut3 (
        .clk(clk), .res(res3), .mode(mode3), .sel(sel3), .in_data(in_data3),
        .in_valid(iv3), .in_ready(ir3), .out_data(od3),
        .out_ch(och3), .out_valid(ov3), .out_ready(ordy3)
    );

    typedef struct {
        logic       res;
        logic       mode;
        logic [1:0] sel;
        logic [3:0] iv;
        logic       ordy;
        logic [3:0] ir;
        logic       ov;
        logic [1:0] ch;
        logic [31:0] data;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] r = '0;
        if (res || !(!m_valid || out_ready)) return r;
        if (mode == 1'b0) begin
            if (int'(sel) < N) r[sel] = 1'b1;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (in_valid[(m_ptr + k) % N]) begin
                    r[(m_ptr + k) % N] = 1'b1;
                    break;
                end
            end
        end
        return r;
    endfunction

    task automatic model_update(input logic [N-1:0] er);
        if (res) begin
            m_valid = 1'b0; m_data = '0; m_ch = 0; m_ptr = 0;
        end else if ((in_valid & er) != '0) begin
            for (int g = 0; g < N; g++) begin
                if (er[g]) begin
                    m_valid = 1'b1;
                    m_data  = in_data[g*W +: W];
                    m_ch    = g;
                    if (mode) m_ptr = (g + 1) % N;
                end
            end
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
    endtask

    // One clock: in_ready sampled mid-cycle, outputs sampled 1ns after the edge.
    task automatic tick(output logic [N-1:0] ir_seen);
        logic [N-1:0] er;
        @(negedge clk);
        er = model_ready();
        ir_seen = in_ready;
        check("in_ready", 64'(in_ready), 64'(er));
        @(posedge clk);
        model_update(er);
        #1;
        check("out_valid", 64'(out_valid), 64'(m_valid));
        check("out_data", 64'(out_data), 64'(m_data));
        check("out_ch", 64'(out_ch), 64'(m_ch));
    endtask

    task automatic drive(input logic r, input logic md, input logic [1:0] s,
                         input logic [3:0] iv, input logic ordy);
        res = r; mode = md; sel = s; in_valid = iv; out_ready = ordy;
    endtask

    task automatic tick3();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [N-1:0] irs;

        m_valid = 1'b0; m_data = '0; m_ch = 0; m_ptr = 0;
        res3 = 1'b1; mode3 = 1'b0; sel3 = 2'd0; in_data3 = 24'h332211; iv3 = 3'b000; ordy3 = 1'b1;
        for (int i = 0; i < N; i++) in_data[i*W +: W] = 32'hA0 + 32'(i);

        //           res mode sel  iv      ordy  ir       ov  ch  data
        vecs[0]  = '{1, 1, 0, 4'b1111, 1, 4'b0000, 0, 0, 32'h0};
        vecs[1]  = '{1, 1, 0, 4'b1111, 1, 4'b0000, 0, 0, 32'h0};
        vecs[2]  = '{0, 1, 0, 4'b1111, 1, 4'b0001, 1, 0, 32'hA0};
        vecs[3]  = '{0, 1, 0, 4'b1111, 1, 4'b0010, 1, 1, 32'hA1};
        vecs[4]  = '{0, 1, 0, 4'b1111, 1, 4'b0100, 1, 2, 32'hA2};
        vecs[5]  = '{0, 1, 0, 4'b1111, 1, 4'b1000, 1, 3, 32'hA3};
        vecs[6]  = '{0, 1, 0, 4'b1111, 1, 4'b0001, 1, 0, 32'hA0};
        vecs[7]  = '{0, 1, 0, 4'b1111, 1, 4'b0010, 1, 1, 32'hA1};
        vecs[8]  = '{0, 1, 0, 4'b1111, 1, 4'b0100, 1, 2, 32'hA2};
        vecs[9]  = '{0, 1, 0, 4'b1111, 1, 4'b1000, 1, 3, 32'hA3};
        vecs[10] = '{0, 0, 2, 4'b1111, 1, 4'b0100, 1, 2, 32'hA2};
        vecs[11] = '{0, 0, 2, 4'b1111, 0, 4'b0000, 1, 2, 32'hA2};
        vecs[12] = '{0, 1, 0, 4'b1111, 0, 4'b0000, 1, 2, 32'hA2};
        vecs[13] = '{0, 1, 0, 4'b1111, 1, 4'b0001, 1, 0, 32'hA0};
        vecs[14] = '{0, 1, 0, 4'b0000, 1, 4'b0000, 0, 0, 32'hA0};
        vecs[15] = '{0, 1, 0, 4'b1000, 0, 4'b1000, 1, 3, 32'hA3};
        vecs[16] = '{0, 1, 0, 4'b1001, 1, 4'b0001, 1, 0, 32'hA0};
        vecs[17] = '{1, 1, 0, 4'b1111, 0, 4'b0000, 0, 0, 32'h0};
        vecs[18] = '{0, 1, 0, 4'b0010, 1, 4'b0010, 1, 1, 32'hA1};

        for (int v = 0; v < 19; v++) begin
            drive(vecs[v].res, vecs[v].mode, vecs[v].sel, vecs[v].iv, vecs[v].ordy);
            tick(irs);
            check($sformatf("vec%0d_in_ready", v), 64'(irs), 64'(vecs[v].ir));
            check($sformatf("vec%0d_out_valid", v), 64'(out_valid), 64'(vecs[v].ov));
            check($sformatf("vec%0d_out_ch", v), 64'(out_ch), 64'(vecs[v].ch));
            check($sformatf("vec%0d_out_data", v), 64'(out_data), 64'(vecs[v].data));
        end

        // Fixed select of a float operand.
        drive(1, 1, 0, 4'b1111, 1); tick(irs);
        in_data[2*W +: W] = 32'h3F800000;
        drive(0, 0, 2, 4'b1111, 1); tick(irs);
        check("fixed_in_ready", 64'(irs), 64'(4'b0100));
        check("fixed_data", 64'(out_data), 64'(32'h3F800000));
        check("fixed_ch", 64'(out_ch), 64'(2));

        // Backpressure holds a word; release drains and refills in one cycle.
        in_data[1*W +: W] = 32'hDEADBEEF;
        drive(0, 1, 0, 4'b0010, 1); tick(irs);
        check("bp_load", 64'(out_data), 64'(32'hDEADBEEF));
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 4'b1111, 0); tick(irs);
            check("bp_in_ready", 64'(irs), 64'(4'b0000));
            check("bp_hold", 64'(out_data), 64'(32'hDEADBEEF));
        end
        drive(0, 1, 0, 4'b1111, 1); tick(irs);
        check("bp_release_ready", 64'(irs), 64'(4'b0100));
        check("bp_release_ch", 64'(out_ch), 64'(2));
        check("bp_release_valid", 64'(out_valid), 64'(1));

        // Sparse requests: move pointer to 1, then skip 1 and 2 to reach 3, then wrap to 0.
        drive(0, 1, 0, 4'b0001, 1); tick(irs);
        check("sparse_setup_ch", 64'(out_ch), 64'(0));
        drive(0, 1, 0, 4'b1001, 1); tick(irs);
        check("sparse_skip_ch", 64'(out_ch), 64'(3));
        tick(irs);
        check("sparse_wrap_ch", 64'(out_ch), 64'(0));

        // Randomized traffic against the model.
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < N; i++) in_data[i*W +: W] = $urandom;
            drive(($urandom_range(0, 31) == 0), 1'($urandom), 2'($urandom),
                  4'($urandom), ($urandom_range(0, 3) != 0));
            tick(irs);
        end

        // NCH=3 build: sel=3 selects nothing, sel=2 works.
        tick3();
        tick3();
        res3 = 1'b0; sel3 = 2'd3; iv3 = 3'b111;
        @(negedge clk);
        check("n3_sel3_ready", 64'(ir3), 64'(0));
        tick3();
        check("n3_sel3_no_xfer", 64'(ov3), 64'(0));
        sel3 = 2'd2;
        @(negedge clk);
        check("n3_sel2_ready", 64'(ir3), 64'(3'b100));
        tick3();
        check("n3_sel2_valid", 64'(ov3), 64'(1));
        check("n3_sel2_ch", 64'(och3), 64'(2));
        check("n3_sel2_data", 64'(od3), 64'(8'h33));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
